// File: rtl/mul_seq_32.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies magnitudes over 32 cycles of one add each, then applies the sign.
module mul_seq_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_result;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic               r_neg;
    logic               r_done;

    logic               w_load;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_fixed;

    // MULH/MULHSU take rs1 as signed; only MULH takes rs2 as signed.
    assign w_a_neg = (op[0] ^ op[1]) & a_in[WIDTH-1];
    assign w_b_neg = (op == 2'b01) & b_in[WIDTH-1];
    assign w_a_mag = w_a_neg ? ('0 - a_in) : a_in;
    assign w_b_mag = w_b_neg ? ('0 - b_in) : b_in;

    assign w_add   = r_lo[0] ? r_mcand : '0;
    assign w_sum   = {1'b0, r_hi} + {1'b0, w_add};
    assign w_prod  = {r_hi, r_lo};
    assign w_fixed = r_neg ? ('0 - w_prod) : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_CALC;
                S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
                S_FIX:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (r_state != S_IDLE);
        w_load = (r_state == S_IDLE) && start && !flush;
        done   = r_done;
        result = r_result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_op    <= op;
                r_mcand <= w_a_mag;
                r_lo    <= w_b_mag;
                r_hi    <= '0;
                r_cnt   <= '0;
                r_neg   <= w_a_neg ^ w_b_neg;
            end else if (r_state == S_CALC && !flush) begin
                // Add-then-shift: carry enters hi MSB, hi LSB enters lo MSB.
                r_hi  <= w_sum[WIDTH:1];
                r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end else if (r_state == S_FIX && !flush) begin
                r_result <= (r_op == 2'b00) ? w_fixed[WIDTH-1:0] : w_fixed[2*WIDTH-1:WIDTH];
                r_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: stimulus pushes expected results, a monitor
// pops and checks value and 34-cycle latency on every done pulse.
module tb_mul_seq_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    mul_seq_32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int unsigned t0;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   next_id  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Monitor: every done pulse must match the oldest pending operation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h expected no pending operation", result);
            end else begin
                e = sb.pop_front();
                check32($sformatf("op%0d_result", e.id), result, e.exp);
                check32($sformatf("op%0d_latency", e.id), cyc - e.t0, 32'd34);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after issue.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int unsigned w = 0;
        while (busy === 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_wait: got busy=1 after 200 cycles expected busy=0");
        end
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (push) begin
            sb.push_back('{exp, cyc, next_id});
            next_id++;
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while ((sb.size() != 0 || busy === 1'b1) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || busy === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_done", {31'b0, done}, 32'd0);
        check32("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7 x -3: low word, busy for exactly 33 cycles, done at k+34
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            @(negedge clk);
        end
        check32("mul7_busy_cycles", bcnt, 32'd33);
        check32("mul7_done_at_k34", {31'b0, done}, 32'd1);
        drain();

        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        issue(2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 1'b1);
        drain();

        // Back-to-back: second start lands in the done cycle; a k+10 start is ignored
        issue(2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
        repeat (9) @(negedge clk);
        op    = 2'b11;
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (23) @(negedge clk);
        check32("b2b_idle_at_k34", {31'b0, busy}, 32'd0);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1);
        drain();

        // Flush at k+20: idle at k+21, no done, result unchanged
        issue(2'b00, 32'h0000_1234, 32'd2, 32'h0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check32("flush_busy_k21", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check32("flush_result_held", result, 32'h0000_0001);

        op    = 2'b00;
        a_in  = 32'd5;
        b_in  = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check32("flush_start_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check32("flush_start_result", result, 32'h0000_0001);

        // Reset mid-CALC with start held high
        issue(2'b00, 32'd9, 32'd9, 32'h0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        a_in  = 32'd3;
        b_in  = 32'd3;
        @(negedge clk);
        check32("midrst_busy", {31'b0, busy}, 32'd0);
        check32("midrst_done", {31'b0, done}, 32'd0);
        check32("midrst_result", result, 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd6, 32'd7, 32'h0000_002A, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = 32'h8000_0000;
            if (i % 15 == 0) rb = 32'hFFFF_FFFF;
            issue(ro, ra, rb, ref_mul(ro, ra, rb), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
